punch_upper: RTL and testbench

PUNCH_UPPER -- requirements
Module: punch_upper

---
 rtl/punch_upper.sv | 107 ++++++++++
 tb/tb_punch_upper.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/punch_upper.sv
// punch_upper: word-to-serial framer, LSB-first payload
// followed by one even-parity beat flagged with out_last.
module punch_upper #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic [7:0]       words_sent
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             par_q, par_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       ws_q, ws_d;

  // Handshake signals and beat outputs decoded from registered state
  always_comb begin
    in_ready   = (state_q == IDLE) && !reset;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_bit    = 1'b0;
    words_sent = ws_q;
    unique case (state_q)
      SHIFT: begin
        out_valid = 1'b1;
        out_bit   = sh_q[0];
      end
      PARITY: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_bit   = par_q;
      end
      default: ;
    endcase
  end

  // Next-state: load on accept, shift on beat handshake
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    ws_d    = ws_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sh_d    = in_data;
          par_d   = ^in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (out_ready) begin
          sh_d  = sh_q >> 1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (out_ready) begin
          ws_d    = ws_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
      ws_q    <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      ws_q    <= ws_d;
    end
  end

endmodule

// File: tb/tb_punch_upper.sv
// tb_punch_upper: randomized scoreboard bench for punch_upper.
// Accepted words expand into expected beat queues; monitor pops.
module tb_punch_upper;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         out_bit;
  logic         out_valid;
  logic         out_last;
  logic         out_ready = 1'b0;
  logic [7:0]   words_sent;

  punch_upper #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  // {last, bit} per expected beat
  logic [1:0] q[$];
  int checks = 0;
  int errors = 0;
  int frames = 0;
  int cyc = 0;
  int acc_cyc = -1;
  int popped = 0;
  int rdy_mode = 0;
  bit full_rdy = 1'b0;
  bit exp_rdy;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic void push_word(input logic [W-1:0] d);
    for (int i = 0; i < W; i++)
      q.push_back({1'b0, d[i]});
    q.push_back({1'b1, 1'($countones(d) % 2)});
  endfunction

  // out_ready pattern: steady, toggling or random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compare DUT against reference queue mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      chk("in_ready_rst", in_ready, 0);
      q.delete();
      frames = 0;
      acc_cyc = -1;
    end else begin
      exp_rdy = (q.size() == 0);
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, !exp_rdy);
      chk("words_sent", words_sent, frames % 256);
      if (exp_rdy) begin
        chk("idle_bit", out_bit, 0);
        chk("idle_last", out_last, 0);
        if (acc_cyc >= 0) begin
          if (full_rdy) chk("spacing", cyc - acc_cyc, W + 2);
          acc_cyc = -1;
        end
      end else begin
        chk("beat_bit", out_bit, q[0][0]);
        chk("beat_last", out_last, q[0][1]);
        if (!out_ready) full_rdy = 1'b0;
        else begin
          if (q[0][1]) frames++;
          popped++;
          void'(q.pop_front());
        end
      end
      if (in_valid && exp_rdy) begin
        push_word(in_data);
        acc_cyc = cyc;
        full_rdy = 1'b1;
        popped = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    bit ok = 1'b0;
    in_data = d;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      step();
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      step();
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 0, 1);
    step();
  endtask

  initial begin
    int g;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    step();
    rdy_mode = 0;
    send(8'hA5);
    wait_done();
    rdy_mode = 1;
    send(8'h07);
    wait_done();
    rdy_mode = 2;
    for (int i = 0; i < 60; i++) begin
      in_data = W'($urandom);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    wait_done();
    rdy_mode = 0;
    send(W'($urandom));
    g = 0;
    while (popped < 3 && g < 100) begin
      step();
      g++;
    end
    if (popped < 3) chk("beat_timeout", 0, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    rdy_mode = 2;
    for (int i = 0; i < 30; i++) begin
      send(W'($urandom));
      repeat ($urandom_range(0, 3)) step();
    end
    wait_done();
    rdy_mode = 0;
    g = 0;
    in_valid = 1'b1;
    while (frames < 300 && g < 5000) begin
      in_data = W'($urandom);
      step();
      g++;
    end
    in_valid = 1'b0;
    if (frames < 300) chk("wrap_timeout", 0, 1);
    wait_done();
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
